// File: rtl/morse_pkg.sv
// Shared symbol codes, FSM state type and result constants for the Morse sequencer.
package morse_pkg;
  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_END  = 2'b11;

  localparam int         NUM_LANES   = 4;
  localparam int         LANE_W      = 8;
  localparam int         NUM_LETTERS = 26;
  localparam logic [4:0] INVALID_IDX = 5'd31;

  typedef logic [NUM_LANES-1:0][LANE_W-1:0] lanes_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EVAL    = 2'd1,
    OUT     = 2'd2
  } state_t;
endpackage

// File: rtl/morse_lane_buf.sv
// Symbol lane buffer: four classifier lanes, symbol count (saturating at 4) and sticky overflow.
module morse_lane_buf
  import morse_pkg::*;
#(
  parameter logic [7:0] EMPTY_CODE = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [7:0] wr_byte,
  input  logic       clr,
  output lanes_t     lanes,
  output logic [2:0] sym_cnt,
  output logic       ovf
);
  localparam logic [2:0] FULL = 3'(NUM_LANES);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             lanes[i] <= EMPTY_CODE;
      else if (clr)                           lanes[i] <= EMPTY_CODE;
      else if (wr && sym_cnt == 3'(i))        lanes[i] <= wr_byte;
    end
  end

  // Symbols beyond the fourth leave the lanes alone and only flag overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt <= '0;
      ovf     <= 1'b0;
    end else if (clr) begin
      sym_cnt <= '0;
      ovf     <= 1'b0;
    end else if (wr) begin
      if (sym_cnt == FULL) ovf     <= 1'b1;
      else                 sym_cnt <= sym_cnt + 3'd1;
    end
  end
endmodule

// File: rtl/morse_seq_ctrl.sv
// Sequencer around the combinational Morse classifier: collect symbols, settle, capture, hand off.
// Optional idle-timeout letter termination is enabled by defining MORSE_TIMEOUT_EN.
module morse_seq_ctrl
  import morse_pkg::*;
#(
  parameter logic [7:0] DOT_CODE   = 8'd127,
  parameter logic [7:0] DASH_CODE  = 8'd255,
  parameter logic [7:0] EMPTY_CODE = 8'd0,
  parameter int         NET_LAT    = 1,
  parameter int         TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_valid,
  input  logic [1:0] sym_code,
  output logic       sym_ready,
  output logic [7:0] net_in1,
  output logic [7:0] net_in2,
  output logic [7:0] net_in3,
  output logic [7:0] net_in4,
  input  logic [4:0] net_out,
  output logic       letter_valid,
  output logic [4:0] letter_idx,
  output logic       letter_err,
  input  logic       letter_ready
);
  state_t     state, state_nxt;
  logic [3:0] lat_cnt, lat_nxt;
  lanes_t     lanes;
  logic [2:0] sym_cnt;
  logic       ovf;
  logic       sym_hs, is_mark, is_end, term, cap, clr;
  logic [4:0] idx_nxt;
  logic       err_nxt;

  // Ready depends on the registered state only.
  assign sym_ready = (state == COLLECT);
  assign sym_hs    = sym_valid & sym_ready;
  assign is_mark   = sym_hs && (sym_code == SYM_DOT || sym_code == SYM_DASH);
  assign is_end    = sym_hs && sym_code == SYM_END && (sym_cnt != 3'd0 || ovf);

`ifdef MORSE_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        pending, timeout_hit;

  assign pending     = (sym_cnt != 3'd0) || ovf;
  assign timeout_hit = (state == COLLECT) && pending && (idle_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               idle_cnt <= '0;
    else if (state != COLLECT || sym_hs || timeout_hit) idle_cnt <= '0;
    else if (pending)                         idle_cnt <= idle_cnt + 16'd1;
  end

  assign term = is_end || timeout_hit;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign term = is_end;
`endif

  morse_lane_buf #(.EMPTY_CODE(EMPTY_CODE)) u_lane_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (is_mark),
    .wr_byte ((sym_code == SYM_DASH) ? DASH_CODE : DOT_CODE),
    .clr     (clr),
    .lanes   (lanes),
    .sym_cnt (sym_cnt),
    .ovf     (ovf)
  );

  assign net_in1 = lanes[0];
  assign net_in2 = lanes[1];
  assign net_in3 = lanes[2];
  assign net_in4 = lanes[3];

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    cap       = 1'b0;
    clr       = 1'b0;
    idx_nxt   = net_out;
    err_nxt   = 1'b0;
    if (ovf || net_out >= 5'(NUM_LETTERS)) begin
      idx_nxt = INVALID_IDX;
      err_nxt = 1'b1;
    end
    unique case (state)
      COLLECT: if (term) begin
        state_nxt = EVAL;
        lat_nxt   = 4'(NET_LAT);
      end
      EVAL: if (lat_cnt == 4'd0) begin
        cap       = 1'b1;
        state_nxt = OUT;
      end else begin
        lat_nxt = lat_cnt - 4'd1;
      end
      OUT: if (letter_ready) begin
        clr       = 1'b1;
        state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= COLLECT;
      lat_cnt      <= '0;
      letter_valid <= 1'b0;
      letter_idx   <= '0;
      letter_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
      if (cap) begin
        letter_valid <= 1'b1;
        letter_idx   <= idx_nxt;
        letter_err   <= err_nxt;
      end else if (clr) begin
        letter_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_morse_seq_ctrl.sv
// Directed bench for morse_seq_ctrl with a stub classifier driven from the stimulus.
module tb_morse_seq_ctrl;
  import morse_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sym_valid = 1'b0;
  logic [1:0] sym_code = SYM_NONE;
  logic       sym_ready;
  logic [7:0] net_in1, net_in2, net_in3, net_in4;
  logic [4:0] net_out = 5'd0;
  logic       letter_valid;
  logic [4:0] letter_idx;
  logic       letter_err;
  logic       letter_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  morse_seq_ctrl #(.NET_LAT(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_code(sym_code),
    .sym_ready(sym_ready), .net_in1(net_in1), .net_in2(net_in2),
    .net_in3(net_in3), .net_in4(net_in4), .net_out(net_out),
    .letter_valid(letter_valid), .letter_idx(letter_idx),
    .letter_err(letter_err), .letter_ready(letter_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one symbol; returns just after the accepting edge.
  task automatic send(input logic [1:0] code);
    int n = 0;
    @(negedge clk);
    while (!sym_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_ready_timeout", 1, 0);
    sym_valid = 1'b1;
    sym_code  = code;
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    sym_code  = SYM_NONE;
  endtask

  // Count falling edges until letter_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!letter_valid && n < 60);
    if (!letter_valid) chk("wait_valid_timeout", 1, 0);
  endtask

  task automatic ack();
    @(negedge clk);
    letter_ready = 1'b1;
    @(posedge clk);
    #1;
    letter_ready = 1'b0;
  endtask

  function automatic logic [31:0] lanes_w();
    return {net_in1, net_in2, net_in3, net_in4};
  endfunction

  initial begin
    int n;
    logic seen;

    #12;
    chk("rst_sym_ready", 32'(sym_ready), 1);
    chk("rst_valid", 32'(letter_valid), 0);
    chk("rst_idx", 32'(letter_idx), 0);
    chk("rst_lanes", lanes_w(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // "A": dot, dash, end; valid at k+3 with NET_LAT=1
    net_out = 5'd0;
    send(SYM_DOT); send(SYM_DASH); send(SYM_END);
    wait_valid(n);
    chk("a_latency", 32'(n), 3);
    chk("a_lanes", lanes_w(), 32'h7fff0000);
    chk("a_idx", 32'(letter_idx), 0);
    chk("a_err", 32'(letter_err), 0);
    chk("a_out_sym_ready", 32'(sym_ready), 0);
    ack();
    @(negedge clk);
    chk("a_ready_after_ack", 32'(sym_ready), 1);
    chk("a_lanes_cleared", lanes_w(), 0);

    // Four dashes, downstream stalls five cycles
    net_out = 5'd14;
    repeat (4) send(SYM_DASH);
    send(SYM_END);
    chk("o_eval_lanes", lanes_w(), 32'hffffffff);
    wait_valid(n);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!letter_valid || letter_idx != 5'd14 || letter_err || sym_ready) seen = 1'b1;
      net_out = 5'(i);
      @(negedge clk);
    end
    chk("o_stall_stable", 32'(seen), 0);
    chk("o_idx", 32'(letter_idx), 14);
    ack();
    @(negedge clk);
    chk("o_lanes_empty", lanes_w(), 0);
    chk("o_valid_dropped", 32'(letter_valid), 0);

    // Five dots -> overflow
    net_out = 5'd3;
    repeat (5) send(SYM_DOT);
    send(SYM_END);
    @(negedge clk);
    chk("ovf_eval_lanes", lanes_w(), 32'h7f7f7f7f);
    wait_valid(n);
    chk("ovf_idx", 32'(letter_idx), 31);
    chk("ovf_err", 32'(letter_err), 1);
    ack();

    // Bare end marker is swallowed
    send(SYM_END);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (letter_valid || !sym_ready) seen = 1'b1;
    end
    chk("bare_end_silent", 32'(seen), 0);

    // Classifier index out of range
    net_out = 5'd27;
    send(SYM_DOT); send(SYM_END);
    wait_valid(n);
    chk("range_idx", 32'(letter_idx), 31);
    chk("range_err", 32'(letter_err), 1);
    ack();

`ifdef MORSE_TIMEOUT_EN
    net_out = 5'd4;
    send(SYM_DOT);
    n = 0;
    @(negedge clk);
    while (sym_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_idle_cycles", 32'(n), 8);
    wait_valid(n);
    chk("timeout_idx", 32'(letter_idx), 4);
    chk("timeout_err", 32'(letter_err), 0);
    ack();
`else
    net_out = 5'd4;
    send(SYM_DOT);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (letter_valid || !sym_ready) seen = 1'b1;
    end
    chk("no_timeout", 32'(seen), 0);
    send(SYM_END);
    wait_valid(n);
    chk("no_timeout_idx", 32'(letter_idx), 4);
    ack();
`endif

    // Reset during EVAL discards the letter
    net_out = 5'd9;
    send(SYM_DOT); send(SYM_DASH); send(SYM_END);
    @(negedge clk);
    chk("mid_eval_ready", 32'(sym_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_eval_sym_ready", 32'(sym_ready), 1);
    chk("rst_eval_valid", 32'(letter_valid), 0);
    chk("rst_eval_lanes", lanes_w(), 0);
    chk("rst_eval_idx", 32'(letter_idx), 0);
    chk("rst_eval_err", 32'(letter_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    net_out = 5'd0;
    send(SYM_DOT); send(SYM_DASH); send(SYM_END);
    wait_valid(n);
    chk("post_rst_latency", 32'(n), 3);
    chk("post_rst_idx", 32'(letter_idx), 0);
    chk("post_rst_err", 32'(letter_err), 0);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/morse_seq_ctrl.md
# morse_seq_ctrl

Sequencing controller for the combinational Morse classifier `net`. It accepts a stream of dot/dash/end-of-letter symbols from a keyer front end over a valid/ready handshake. It packs up to four symbols into the four 8-bit classifier lanes and holds them stable while the classifier settles. It then captures the 5-bit letter index and presents it downstream on a second valid/ready handshake.

## Interface
Parameters:
- `DOT_CODE`, 8'd127: lane byte driven for a dot.
- `DASH_CODE`, 8'd255: lane byte driven for a dash.
- `EMPTY_CODE`, 8'd0: lane byte for an unused position.
- `NET_LAT`, 1: extra settle cycles after the inputs become stable, before the result is captured. Range 0..15.
- `TIMEOUT`, 64: idle cycles that terminate a letter. Used only with `MORSE_TIMEOUT_EN`. Range 2..65535.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sym_valid` in 1: symbol offered.
- `sym_code` in 2: 2'b01 dot, 2'b10 dash, 2'b11 end-of-letter, 2'b00 ignored (accepted, no effect).
- `sym_ready` out 1: controller can accept a symbol.
- `net_in1`..`net_in4` out 8 each: classifier lanes; `net_in1` holds the first symbol.
- `net_out` in 5: classifier letter index.
- `letter_valid` out 1: result available.
- `letter_idx` out 5: captured index, 0..25; 5'd31 on error.
- `letter_err` out 1: overflow or out-of-range index.
- `letter_ready` in 1: downstream accepts the result.

## Operation
- FSM states: COLLECT, EVAL, OUT.
- COLLECT:
  - `sym_ready`=1.
  - Dot/dash handshake: writes lane `sym_cnt` and increments `sym_cnt` (3 bits, saturates at 4).
  - 5th or later dot/dash: lanes unchanged, sticky `ovf` set.
  - End-of-letter with `sym_cnt`=0 and `ovf`=0: accepted and ignored; no output, state stays COLLECT.
  - Any other end-of-letter: go to EVAL with `lat_cnt`=NET_LAT.
- EVAL:
  - `sym_ready`=0; lanes held constant.
  - `lat_cnt` decrements each cycle.
  - In the cycle with `lat_cnt`=0, register the result:
    - `ovf`: idx=31, err=1.
    - else `net_out`>25: idx=31, err=1.
    - else idx=`net_out`, err=0.
  - Go to OUT.
- OUT:
  - `letter_valid`=1; `letter_idx`/`letter_err` stable until the handshake.
  - On `letter_valid`&`letter_ready`: lanes to EMPTY_CODE, `sym_cnt`=0, `ovf`=0, go to COLLECT.
  - `sym_ready` stays 0 throughout OUT; no symbol lookahead.
- Reset values: state COLLECT, all lanes EMPTY_CODE, `sym_cnt`=0, `ovf`=0, `sym_ready`=1, `letter_valid`=0, `letter_idx`=0, `letter_err`=0.
- Reset asserted mid-EVAL or mid-OUT discards the letter; no partial output.

## Timing
- `sym_ready` is a registered function of state only, with no combinational path from `sym_valid`. `letter_valid` is a registered output.
- End-of-letter handshake at edge k: EVAL occupies cycles k+1 .. k+1+NET_LAT; `letter_valid` rises in cycle k+NET_LAT+2.
- A lane is updated at the edge of its handshake and is visible on `net_inN` the next cycle.
- `letter_ready` high in the first OUT cycle: `sym_ready`=1 on the following cycle, so a symbol-to-symbol gap of NET_LAT+3 cycles.
- `letter_ready` held low: OUT persists indefinitely with outputs stable.

## Configuration
- `MORSE_TIMEOUT_EN` defined:
  - 16-bit `idle_cnt` counts COLLECT cycles with no handshake, while `sym_cnt`>0 or `ovf`=1.
  - Any handshake clears `idle_cnt`.
  - When `idle_cnt` reaches TIMEOUT-1, the next edge acts as an end-of-letter.
  - An explicit end marker and a timeout on the same cycle produce one letter.
- `MORSE_TIMEOUT_EN` undefined: no counter; `TIMEOUT` is ignored; only explicit end markers terminate a letter.

## Structure
- Package `morse_pkg`:
  - Symbol code localparams: SYM_NONE, SYM_DOT, SYM_DASH, SYM_END.
  - State enum: COLLECT, EVAL, OUT.
  - NUM_LETTERS=26, INVALID_IDX=5'd31.
- Sub-module `morse_lane_buf`: four 8-bit lanes plus `sym_cnt`/`ovf`, with write, clear and saturation logic. FSM, latency counter and result registers stay in the top level.

## Test plan
- Classifier stub returns 0. Dot, dash, end -> lanes 127,255,0,0; `letter_valid` in cycle k+3 (NET_LAT=1); idx 0, err 0.
- Four dashes, end, stub returns 14; `letter_ready` low for 5 cycles -> idx 14 held stable all 5 cycles; `sym_ready`=0 throughout; lanes EMPTY the cycle after the handshake.
- Five dots then end -> idx 31, err 1; lanes still 127,127,127,127 during EVAL.
- End with no symbols -> no `letter_valid` for 20 cycles; `sym_ready` stays 1. Stub returns 27 for a one-dot letter -> idx 31, err 1.
- With `MORSE_TIMEOUT_EN`, TIMEOUT=8: one dot then idle -> EVAL entered after 8 idle cycles; idx from stub. Without the macro: no output after 100 idle cycles.
- Assert `rst_n` low in an EVAL cycle -> all outputs take their reset values immediately. After release, a clean "A" (dot, dash, end) produces idx 0.
